// File: rtl/rv_pkg.sv
// Shared register-file geometry and helpers for the RV issue-side blocks.
package rv_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Number of set bits in a register-file-wide mask.
    function automatic logic [REG_IDX_W:0] popcount_regs(input logic [NREGS-1:0] mask);
        logic [REG_IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{REG_IDX_W{1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rv_reg_fwd.sv
// One read port's writeback forward register: captures data written to the
// register being read this cycle and substitutes it for the stale RF output.
module rv_reg_fwd
    import rv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  reg_idx_t        i_rs,
    input  logic            i_wb_valid,
    input  reg_idx_t        i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic [XLEN-1:0] i_rf_data,
    output logic [XLEN-1:0] o_data
);

    logic            fwd_q;
    logic            fwd_d;
    logic [XLEN-1:0] fwd_data_q;
    logic [XLEN-1:0] fwd_data_d;

    // Forward decision: x0 reads never forward since the RF always returns zero.
    always_comb begin
        fwd_d      = 1'b0;
        fwd_data_d = fwd_data_q;
        if (i_wb_valid && (i_wb_rd == i_rs) && (i_rs != 5'd0)) begin
            fwd_d      = 1'b1;
            fwd_data_d = i_wb_data;
        end else begin
            fwd_d      = 1'b0;
            fwd_data_d = fwd_data_q;
        end
    end

    // Forward flag and captured data.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign o_data = fwd_q ? fwd_data_q : i_rf_data;

endmodule

// File: rtl/rv_reg_scoreboard.sv
// Issue-side register scoreboard: tracks pending writes, stalls decode on
// RAW/WAW hazards, drives the RF write port and forwards around read latency.
module rv_reg_scoreboard
    import rv_pkg::*;
#(
    parameter int PERF_W    = 32,
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_issue_valid,
    output logic              o_issue_ready,
    input  reg_idx_t          i_rs1,
    input  reg_idx_t          i_rs2,
    input  logic              i_use_rs1,
    input  logic              i_use_rs2,
    input  reg_idx_t          i_rd,
    input  logic              i_rd_we,
    input  logic              i_wb_valid,
    input  reg_idx_t          i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output reg_idx_t          o_rf_rs1,
    output reg_idx_t          o_rf_rs2,
    input  logic [XLEN-1:0]   i_rf_data1,
    input  logic [XLEN-1:0]   i_rf_data2,
    output logic              o_rf_write,
    output reg_idx_t          o_rf_rd,
    output logic [XLEN-1:0]   o_rf_data,
    output logic [XLEN-1:0]   o_data1,
    output logic [XLEN-1:0]   o_data2,
    output logic [REG_IDX_W:0] o_pending,
    output logic              o_idle,
    output logic              o_err,
    output logic [PERF_W-1:0] o_stall_cnt
);

    logic [NREGS-1:0]   busy_q;
    logic [NREGS-1:0]   busy_d;
    logic [REG_IDX_W:0] pending_q;
    logic               err_q;
    logic               err_d;
    logic [PERF_W-1:0]  stall_q;
    logic [PERF_W-1:0]  stall_d;

    logic wb_live_s;
    logic clr1_s;
    logic clr2_s;
    logic raw1_s;
    logic raw2_s;
    logic waw_s;
    logic ready_s;
    logic fire_s;

    // Hazard detection; a same-cycle writeback always resolves WAW, but only
    // resolves RAW when the bypass path is enabled.
    always_comb begin
        wb_live_s = i_wb_valid && (i_wb_rd != 5'd0);
        clr1_s    = i_wb_valid && (i_wb_rd == i_rs1) && BYPASS_WB;
        clr2_s    = i_wb_valid && (i_wb_rd == i_rs2) && BYPASS_WB;
        raw1_s    = i_use_rs1 && (i_rs1 != 5'd0) && busy_q[i_rs1] && !clr1_s;
        raw2_s    = i_use_rs2 && (i_rs2 != 5'd0) && busy_q[i_rs2] && !clr2_s;
        waw_s     = i_rd_we && (i_rd != 5'd0) && busy_q[i_rd]
                    && !(i_wb_valid && (i_wb_rd == i_rd));
        ready_s   = !(raw1_s || raw2_s || waw_s);
        fire_s    = i_issue_valid && ready_s;
    end

    // Next busy set: clear on writeback first so a same-register issue re-sets it.
    always_comb begin
        busy_d = busy_q;
        if (wb_live_s) begin
            busy_d[i_wb_rd] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (fire_s && i_rd_we && (i_rd != 5'd0)) begin
            busy_d[i_rd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Sticky error and stall performance counter.
    always_comb begin
        err_d   = err_q || (wb_live_s && !busy_q[i_wb_rd]);
        stall_d = stall_q + {{(PERF_W-1){1'b0}}, (i_issue_valid && !ready_s)};
    end

    // Scoreboard state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
            stall_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= popcount_regs(busy_d);
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end

    rv_reg_fwd u_fwd1 (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_rs       (i_rs1),
        .i_wb_valid (i_wb_valid),
        .i_wb_rd    (i_wb_rd),
        .i_wb_data  (i_wb_data),
        .i_rf_data  (i_rf_data1),
        .o_data     (o_data1)
    );

    rv_reg_fwd u_fwd2 (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_rs       (i_rs2),
        .i_wb_valid (i_wb_valid),
        .i_wb_rd    (i_wb_rd),
        .i_wb_data  (i_wb_data),
        .i_rf_data  (i_rf_data2),
        .o_data     (o_data2)
    );

    assign o_issue_ready = ready_s;
    assign o_rf_rs1      = i_rs1;
    assign o_rf_rs2      = i_rs2;
    assign o_rf_write    = wb_live_s && i_reset_n;
    assign o_rf_rd       = i_wb_rd;
    assign o_rf_data     = i_wb_data;
    assign o_pending     = pending_q;
    assign o_idle        = (pending_q == 6'd0);
    assign o_err         = err_q;
    assign o_stall_cnt   = stall_q;

endmodule

// File: tb/tb_rv_reg_scoreboard.sv
// Directed self-checking bench for rv_reg_scoreboard with hand-computed expectations.
module tb_rv_reg_scoreboard;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_issue_valid;
    logic        o_issue_ready;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        i_use_rs1;
    logic        i_use_rs2;
    logic [4:0]  i_rd;
    logic        i_rd_we;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic [4:0]  o_rf_rs1;
    logic [4:0]  o_rf_rs2;
    logic [31:0] i_rf_data1;
    logic [31:0] i_rf_data2;
    logic        o_rf_write;
    logic [4:0]  o_rf_rd;
    logic [31:0] o_rf_data;
    logic [31:0] o_data1;
    logic [31:0] o_data2;
    logic [5:0]  o_pending;
    logic        o_idle;
    logic        o_err;
    logic [31:0] o_stall_cnt;

    int compared;
    int mismatched;

    rv_reg_scoreboard #(.PERF_W(32), .BYPASS_WB(1'b1)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_issue_valid (i_issue_valid),
        .o_issue_ready (o_issue_ready),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .i_use_rs1     (i_use_rs1),
        .i_use_rs2     (i_use_rs2),
        .i_rd          (i_rd),
        .i_rd_we       (i_rd_we),
        .i_wb_valid    (i_wb_valid),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .o_rf_rs1      (o_rf_rs1),
        .o_rf_rs2      (o_rf_rs2),
        .i_rf_data1    (i_rf_data1),
        .i_rf_data2    (i_rf_data2),
        .o_rf_write    (o_rf_write),
        .o_rf_rd       (o_rf_rd),
        .o_rf_data     (o_rf_data),
        .o_data1       (o_data1),
        .o_data2       (o_data2),
        .o_pending     (o_pending),
        .o_idle        (o_idle),
        .o_err         (o_err),
        .o_stall_cnt   (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen 1-2 time units after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_issue_valid = 1'b0;
        i_use_rs1     = 1'b0;
        i_use_rs2     = 1'b0;
        i_rs1         = 5'd0;
        i_rs2         = 5'd0;
        i_rd          = 5'd0;
        i_rd_we       = 1'b0;
        i_wb_valid    = 1'b0;
        i_wb_rd       = 5'd0;
        i_wb_data     = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we);
        i_issue_valid = 1'b1;
        i_rs1 = rs1; i_use_rs1 = u1;
        i_rs2 = rs2; i_use_rs2 = u2;
        i_rd  = rd;  i_rd_we   = we;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        i_wb_valid = 1'b1;
        i_wb_rd    = rd;
        i_wb_data  = data;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        idle_inputs();
        i_rf_data1 = 32'h0000_AAAA;
        i_rf_data2 = 32'h0000_0000;
        i_reset_n  = 1'b0;

        // Reset: write port gated, operands pass RF data, counters clear.
        wb(5'd3, 32'h0000_0077);
        #2;
        chk("rst_rf_write", {31'd0, o_rf_write}, 32'd0);
        tick();
        tick();
        chk("rst_data1_pass", o_data1, 32'h0000_AAAA);
        chk("rst_pending", {26'd0, o_pending}, 32'd0);
        chk("rst_idle", {31'd0, o_idle}, 32'd1);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_stall", o_stall_cnt, 32'd0);
        idle_inputs();
        i_reset_n = 1'b1;
        tick();

        // add x5, x1, x2 issues at once.
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
        #1;
        chk("t1_ready", {31'd0, o_issue_ready}, 32'd1);
        chk("t1_rf_rs1", {27'd0, o_rf_rs1}, 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("t1_pending", {26'd0, o_pending}, 32'd1);
        chk("t1_idle", {31'd0, o_idle}, 32'd0);

        // RAW on x5 for three cycles, then writeback 0x1234 releases it.
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        i_rf_data1 = 32'h0000_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_ready", {31'd0, o_issue_ready}, 32'd0);
            tick();
        end
        wb(5'd5, 32'h0000_1234);
        #1;
        chk("t2_ready_on_wb", {31'd0, o_issue_ready}, 32'd1);
        chk("t2_stall_cnt", o_stall_cnt, 32'd3);
        chk("t2_rf_write", {31'd0, o_rf_write}, 32'd1);
        chk("t2_rf_rd", {27'd0, o_rf_rd}, 32'd5);
        chk("t2_rf_data", o_rf_data, 32'h0000_1234);
        tick();
        idle_inputs();
        i_rs1 = 5'd5;
        #1;
        chk("t2_fwd_data1", o_data1, 32'h0000_1234);
        chk("t2_pending", {26'd0, o_pending}, 32'd1);
        chk("t2_stall_hold", o_stall_cnt, 32'd3);

        // Same-cycle bypass: x5 busy again, writeback 0xDEADBEEF in issue cycle.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        chk("t3_issue_x5", {31'd0, o_issue_ready}, 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("t3_pending2", {26'd0, o_pending}, 32'd2);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb(5'd5, 32'hDEAD_BEEF);
        i_rf_data1 = 32'h1111_1111;
        i_rf_data2 = 32'h0000_0022;
        #1;
        chk("t3_bypass_ready", {31'd0, o_issue_ready}, 32'd1);
        tick();
        idle_inputs();
        i_rs1 = 5'd5;
        #1;
        chk("t3_fwd_data1", o_data1, 32'hDEAD_BEEF);
        chk("t3_data2_pass", o_data2, 32'h0000_0022);
        chk("t3_pending1", {26'd0, o_pending}, 32'd1);

        // WAW on x7: stall one cycle, writeback frees it and re-sets busy.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("t4_pending2", {26'd0, o_pending}, 32'd2);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        #1;
        chk("t4_waw_ready", {31'd0, o_issue_ready}, 32'd0);
        tick();
        chk("t4_stall_cnt", o_stall_cnt, 32'd4);
        wb(5'd7, 32'h0000_0007);
        #1;
        chk("t4_waw_release", {31'd0, o_issue_ready}, 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("t4_pending_reset", {26'd0, o_pending}, 32'd2);
        chk("t4_no_err", {31'd0, o_err}, 32'd0);
        wb(5'd7, 32'h0000_0070);
        tick();
        wb(5'd6, 32'h0000_0060);
        tick();
        idle_inputs();
        #1;
        chk("t4_drained", {26'd0, o_pending}, 32'd0);
        chk("t4_idle", {31'd0, o_idle}, 32'd1);
        chk("t4_still_no_err", {31'd0, o_err}, 32'd0);

        // Writeback to idle x9 raises sticky error; x0 writeback is dropped.
        wb(5'd9, 32'h0000_0099);
        #1;
        chk("t5_rf_write_x9", {31'd0, o_rf_write}, 32'd1);
        tick();
        wb(5'd0, 32'h0000_FFFF);
        i_rf_data1 = 32'h0000_0000;
        #1;
        chk("t5_err_set", {31'd0, o_err}, 32'd1);
        chk("t5_rf_write_x0", {31'd0, o_rf_write}, 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("t5_err_sticky", {31'd0, o_err}, 32'd1);
        chk("t5_x0_no_fwd", o_data1, 32'h0000_0000);
        chk("t5_pending", {26'd0, o_pending}, 32'd0);

        // Reset with x3 and x4 busy, then a late writeback to x3.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        tick();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("t6_pending2", {26'd0, o_pending}, 32'd2);
        i_reset_n = 1'b0;
        tick();
        #1;
        chk("t6_rst_pending", {26'd0, o_pending}, 32'd0);
        chk("t6_rst_idle", {31'd0, o_idle}, 32'd1);
        chk("t6_rst_err", {31'd0, o_err}, 32'd0);
        chk("t6_rst_stall", o_stall_cnt, 32'd0);
        i_reset_n = 1'b1;
        wb(5'd3, 32'h0000_0033);
        tick();
        idle_inputs();
        #1;
        chk("t6_late_wb_err", {31'd0, o_err}, 32'd1);

        // Operand 2 forwarding, then fall back to RF data.
        i_rs2 = 5'd12;
        i_rf_data2 = 32'h0000_0033;
        wb(5'd12, 32'hCAFE_F00D);
        tick();
        i_wb_valid = 1'b0;
        #1;
        chk("t7_fwd_data2", o_data2, 32'hCAFE_F00D);
        tick();
        #1;
        chk("t7_data2_rf", o_data2, 32'h0000_0033);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv_reg_scoreboard.md
Name: rv_reg_scoreboard

Overview:
Issue-side controller for the 32x32 register file, which has synchronous reads (data one cycle after address) and one write port. It tracks registers with pending writes and stalls decode on RAW/WAW hazards. It owns the write port for writeback, and forwards same-cycle writeback data around the one-cycle read latency. It sits between decode/issue, the writeback stage and the register file.

Parameters:
PERF_W, 32, width of the stall-cycle performance counter
BYPASS_WB, 1, 1: a writeback clearing a source register in the issue cycle lets issue proceed (data forwarded); 0: issue waits one more cycle

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous, active-low reset
i_issue_valid  in  1  decode presents an instruction
o_issue_ready  out  1  no hazard; issue fires on valid&ready
i_rs1  in  5  source 1 index
i_rs2  in  5  source 2 index
i_use_rs1  in  1  instruction reads rs1
i_use_rs2  in  1  instruction reads rs2
i_rd  in  5  destination index
i_rd_we  in  1  instruction writes rd
i_wb_valid  in  1  writeback strobe
i_wb_rd  in  5  writeback destination
i_wb_data  in  32  writeback data
o_rf_rs1  out  5  register file read address 1 (= i_rs1)
o_rf_rs2  out  5  register file read address 2 (= i_rs2)
i_rf_data1  in  32  register file read data 1 (1-cycle latency)
i_rf_data2  in  32  register file read data 2
o_rf_write  out  1  register file write enable
o_rf_rd  out  5  register file write index
o_rf_data  out  32  register file write data
o_data1  out  32  operand 1, valid the cycle after issue fires
o_data2  out  32  operand 2, valid the cycle after issue fires
o_pending  out  6  number of busy registers
o_idle  out  1  o_pending == 0
o_err  out  1  sticky: writeback to a non-busy register
o_stall_cnt  out  PERF_W  cycles with valid & !ready

Behaviour:
- State: busy[31:1], fwd1/fwd2 flags, fwd1_data/fwd2_data, err flag, stall counter. x0 is never busy.
- Reset, synchronous while i_reset_n=0:
  - busy=0, fwd=0, o_err=0, o_stall_cnt=0, o_pending=0, o_idle=1.
  - o_rf_write=0 during reset; o_data1/o_data2 pass i_rf_data.
- Write port, combinational passthrough:
  - o_rf_write = i_wb_valid & (i_wb_rd!=0) & i_reset_n.
  - o_rf_rd = i_wb_rd, o_rf_data = i_wb_data.
- Hazards, combinational. clr(r) = i_wb_valid & i_wb_rd==r & BYPASS_WB.
  - raw1 = i_use_rs1 & rs1!=0 & busy[rs1] & !clr(rs1); raw2 likewise for rs2.
  - waw = i_rd_we & rd!=0 & busy[rd] & !(i_wb_valid & i_wb_rd==rd).
  - o_issue_ready = !(raw1|raw2|waw).
  - Ready does not depend on i_issue_valid.
- Busy update per cycle:
  - Writeback to r!=0 clears busy[r].
  - Issue fire with i_rd_we & rd!=0 sets busy[rd].
  - Set and clear on the same r in one cycle: set wins (new op pending).
  - A writeback with busy[r]=0 and r!=0 sets o_err; the data is still written.
  - Writeback to x0 is ignored entirely.
- Read forwarding:
  - Read addresses are presented every cycle.
  - If a writeback to i_rs1 (i_rs1!=0) occurs in cycle t, register fwd1=1 and fwd1_data=i_wb_data; otherwise fwd1=0.
  - In cycle t+1, o_data1 = fwd1 ? fwd1_data : i_rf_data1. Operand 2 is symmetric.
  - x0 reads never forward (the register file returns 0).
- o_pending: popcount of busy, registered, updated every cycle.
- o_stall_cnt: increments when i_issue_valid & !o_issue_ready; wraps at 2^PERF_W.
- Reset mid-operation clears all busy bits; subsequent late writebacks raise o_err.

Decomposition:
- Shared package rv_pkg: REG_IDX_W=5, XLEN=32, NREGS=32, typedef reg_idx_t.
- Sub-module rv_reg_fwd: the per-port forward register plus mux, instanced twice.

Test Plan:
- Reset, then issue add x5 with rs1=x1, rs2=x2 -> ready=1; busy[5]=1; o_pending=1 next cycle.
- Issue rd=x5; wb x5=0x1234 three cycles later; a rs1=x5 user presented meanwhile -> ready=0 for 3 cycles; stall_cnt=3.
- BYPASS_WB=1, rs1=x5 busy, wb x5=0xDEADBEEF in the same cycle -> issue fires; o_data1=0xDEADBEEF next cycle, regardless of stale i_rf_data1.
- WAW: rd=x7 busy, new issue rd=x7 -> ready=0 until wb x7, then ready=1 and busy[7] re-set the same cycle.
- Wb x9 with busy[9]=0 -> o_rf_write=1, o_err=1 and sticky until reset; wb x0=0xFFFF -> o_rf_write=0, no err.
- Reset asserted with x3 and x4 busy -> o_pending=0 and o_idle=1 after reset.
